// File: rtl/det_log_pkg.sv
`default_nettype none
// ============================================================================
// Module   : det_log_pkg
// Brief    : Shared state type and encodings for the detect event logger.
// Revision : 1.0
// ============================================================================
package det_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage : det_log_pkg
`default_nettype wire

// File: rtl/det_log_fifo.sv
`default_nettype none
// ============================================================================
// Module   : det_log_fifo
// Brief    : Synchronous FIFO, power-of-two depth, show-ahead head output.
// Revision : 1.0
// ============================================================================
module det_log_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [AW:0]       C_FULL   = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic             w_pop;
    logic             w_push;

    // A push into a full FIFO is still accepted when a pop frees a slot.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    assign full_o  = (count_q == C_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule : det_log_fifo
`default_nettype wire

// File: rtl/detect_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : detect_event_logger
// Brief    : Timestamps detector pulses into a FIFO while armed; counts events.
// Revision : 1.0
// ============================================================================
module detect_event_logger
    import det_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              det,
    input  logic              arm,
    input  logic              disarm,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [TS_W-1:0]   rd_data,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic [1:0]        state_o
);

    state_t               state_q;
    logic [TS_W-1:0]      ts_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                 w_unused_count;

    logic                 w_event;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_start;

    assign w_event = (state_q == ST_RUN) && det;
    assign w_pop   = rd_valid && rd_ready;
    assign w_drop  = w_event && w_fifo_full && !w_pop;
    assign w_start = arm && !disarm;

    assign rd_valid       = !w_fifo_empty;
    assign match_count    = count_q;
    assign overflow       = overflow_q;
    assign state_o        = state_q;
    assign w_unused_count = ^w_fifo_count;

    det_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (w_event && !w_drop),
        .pop_i   (w_pop),
        .din_i   (ts_q),
        .dout_o  (rd_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Every RUN event counts, including the one that gets dropped.
            if (w_event && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        state_q <= ST_RUN;
                        ts_q    <= '0;
                    end
                end
                ST_RUN: begin
                    ts_q <= ts_q + 1'b1;
                    if (disarm) begin
                        state_q <= ST_IDLE;
                    end else if (w_drop) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (w_start) begin
                        state_q    <= ST_RUN;
                        ts_q       <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : detect_event_logger
`default_nettype wire
